piece_gen: RTL and testbench

- Parametrised Tetris piece generator. It replaces the simple wrap counter with an LFSR-driven source that has two modes: uniform and "bag" (each piece type exactly once per bag).
- Keeps a preview queue, so the playfield controller sees the current piece plus the next PREVIEW pieces.
- Sits between the game FSM, which drives start, update and gameover, and the spawn/draw logic, which consumes Index and preview.

---
 rtl/piece_pkg.sv | 35 +++
 rtl/lfsr_gen.sv | 32 +++
 rtl/piece_gen.sv | 146 ++++++++++++++
 tb/tb_piece_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piece_pkg.sv
// piece_pkg: shared types and constants for the piece generator.
//   piece_idx_t   - piece index at the default index width
//   NUM_TYPES_DEF - default number of piece types
//   LFSR_TAPS     - Galois tap mask for the 16-bit LFSR (x^16+x^14+x^13+x^11+1)
//   lfsr_taps()   - maximal-length tap mask for other common LFSR widths
//   SEED_DEF      - default nonzero LFSR seed
//   gen_state_t   - generator state (FILL / READY / FROZEN)
package piece_pkg;

   localparam int NUM_TYPES_DEF = 7;
   localparam int IDX_W_DEF     = 3;

   typedef logic [IDX_W_DEF-1:0] piece_idx_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] SEED_DEF  = 16'hACE1;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_READY  = 2'd1,
      ST_FROZEN = 2'd2
   } gen_state_t;

   // Right-shifting Galois tap masks; unknown widths fall back to the 16-bit mask.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         8:       return 32'h0000_00B8;
         16:      return {16'h0000, LFSR_TAPS};
         24:      return 32'h00E1_0000;
         32:      return 32'h8020_0003;
         default: return {16'h0000, LFSR_TAPS};
      endcase
   endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: right-shifting Galois LFSR with synchronous load.
//   clk      - clock
//   rst      - asynchronous active-high reset, loads SEED
//   en       - advance one step
//   load     - load load_val (takes priority over en)
//   load_val - value to load; caller keeps it nonzero
//   q        - current LFSR state
module lfsr_gen #(
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'hB400),
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= SEED;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         // Bit shifted out of the bottom feeds back through the tap mask.
         q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
      end
   end

endmodule

// File: rtl/piece_gen.sv
// piece_gen: LFSR-driven Tetris piece generator with preview queue.
//   clk, rst      - clock, asynchronous active-high reset
//   start         - synchronous restart: flush queue, clear bag, reseed
//   gameover      - freeze all state while high
//   update        - consume the current piece (one pulse per piece)
//   mode          - 0 = uniform, 1 = bag (each type once per bag)
//   seed_in       - seed sampled on start; 0 selects SEED
//   Index         - current piece (queue slot 0)
//   preview       - slots 1..PREVIEW, slot k at [k*IDX_W-1 -: IDX_W]
//   valid         - queue full, Index/preview meaningful
//   bag_remaining - types not yet drawn in the current bag
module piece_gen
   import piece_pkg::*;
#(
   parameter int                NUM_TYPES = NUM_TYPES_DEF,
   parameter int                IDX_W     = IDX_W_DEF,
   parameter int                PREVIEW   = 3,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(SEED_DEF)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     gameover,
   input  logic                     update,
   input  logic                     mode,
   input  logic [LFSR_W-1:0]        seed_in,
   output logic [IDX_W-1:0]         Index,
   output logic [PREVIEW*IDX_W-1:0] preview,
   output logic                     valid,
   output logic [IDX_W:0]           bag_remaining
);

   localparam int                DEPTH = PREVIEW + 1;
   localparam int                CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
   localparam logic [IDX_W:0]    NT    = (IDX_W+1)'(NUM_TYPES);
   localparam logic [LFSR_W-1:0] TAPS  = LFSR_W'(lfsr_taps(LFSR_W));

   logic [DEPTH-1:0][IDX_W-1:0] slot_reg, slot_next;
   logic [CNT_W-1:0]            count_reg, count_next;
   logic [NUM_TYPES-1:0]        mask_reg, mask_next, mask_set;
   logic [IDX_W:0]              remain_reg, remain_next;
   logic                        valid_reg;
   gen_state_t                  state_reg, resume_reg, run_state;

   logic [LFSR_W-1:0] lfsr_q, load_val;
   logic [IDX_W-1:0]  cand;
   logic [CNT_W-1:0]  tail;
   logic              in_bag, accept, pop, push;

   assign load_val = (seed_in != '0) ? seed_in : SEED;

   lfsr_gen #(
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS),
      .SEED   (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .en       (!gameover),
      .load     (start),
      .load_val (load_val),
      .q        (lfsr_q)
   );

   always_comb begin
      // While frozen, the state to resume in is the one that was left.
      run_state = (state_reg == ST_FROZEN) ? resume_reg : state_reg;
      cand      = lfsr_q[IDX_W-1:0];

      in_bag = 1'b0;
      for (int i = 0; i < NUM_TYPES; i++)
         if (cand == IDX_W'(i)) in_bag = mask_reg[i];

      accept = ({1'b0, cand} < NT) && (!mode || !in_bag);
      pop    = update && valid_reg && !gameover;
      push   = accept && !gameover && ((run_state == ST_FILL) || pop);

      // On a simultaneous pop the tail has already moved down one slot.
      tail = pop ? (count_reg - CNT_W'(1)) : count_reg;

      slot_next = slot_reg;
      if (pop) begin
         for (int i = 0; i < DEPTH-1; i++) slot_next[i] = slot_reg[i+1];
         slot_next[DEPTH-1] = '0;
      end
      if (push)
         for (int i = 0; i < DEPTH; i++)
            if (tail == CNT_W'(i)) slot_next[i] = cand;

      count_next = count_reg;
      if (push && !pop)      count_next = count_reg + CNT_W'(1);
      else if (pop && !push) count_next = count_reg - CNT_W'(1);

      mask_set = mask_reg;
      for (int i = 0; i < NUM_TYPES; i++)
         if (cand == IDX_W'(i)) mask_set[i] = 1'b1;

      // Completing the bag clears the mask in the same cycle.
      mask_next = mask_reg;
      if (push && mode) mask_next = (&mask_set) ? '0 : mask_set;

      remain_next = NT;
      for (int i = 0; i < NUM_TYPES; i++)
         remain_next = remain_next - (IDX_W+1)'(mask_next[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_reg   <= '0;
         count_reg  <= '0;
         mask_reg   <= '0;
         remain_reg <= NT;
         valid_reg  <= 1'b0;
         state_reg  <= ST_FILL;
         resume_reg <= ST_FILL;
      end else if (start) begin
         slot_reg   <= '0;
         count_reg  <= '0;
         mask_reg   <= '0;
         remain_reg <= NT;
         valid_reg  <= 1'b0;
         state_reg  <= ST_FILL;
         resume_reg <= ST_FILL;
      end else if (gameover) begin
         state_reg  <= ST_FROZEN;
         resume_reg <= run_state;
      end else begin
         slot_reg   <= slot_next;
         count_reg  <= count_next;
         mask_reg   <= mask_next;
         remain_reg <= remain_next;
         valid_reg  <= (count_next == FULL);
         state_reg  <= (count_next == FULL) ? ST_READY : ST_FILL;
      end
   end

   assign Index = slot_reg[0];
   for (genvar gi = 1; gi <= PREVIEW; gi++) begin : g_preview
      assign preview[gi*IDX_W-1 -: IDX_W] = slot_reg[gi];
   end
   assign valid         = valid_reg;
   assign bag_remaining = remain_reg;

endmodule

// File: tb/tb_piece_gen.sv
// tb_piece_gen: randomized scoreboard bench for piece_gen against a queue-based
// reference model of the generator rules.
module tb_piece_gen;

   localparam int NT    = 7;
   localparam int IW    = 3;
   localparam int PV    = 3;
   localparam int DEPTH = PV + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, gameover = 1'b0, update = 1'b0, mode = 1'b0;
   logic [15:0]   seed_in = '0;
   logic [IW-1:0] Index;
   logic [PV*IW-1:0] preview;
   logic          valid;
   logic [IW:0]   bag_remaining;

   piece_gen #(
      .NUM_TYPES (NT),
      .IDX_W     (IW),
      .PREVIEW   (PV),
      .LFSR_W    (16),
      .SEED      (16'hACE1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .gameover      (gameover),
      .update        (update),
      .mode          (mode),
      .seed_in       (seed_in),
      .Index         (Index),
      .preview       (preview),
      .valid         (valid),
      .bag_remaining (bag_remaining)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit verbose = 1'b1;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_lfsr;
   int m_q[$];
   bit m_used[NT];

   function automatic int lfsr_next(int x);
      return (x % 2 == 1) ? ((x / 2) ^ 32'h0000_B400) : (x / 2);
   endfunction

   function automatic void model_clear(int sd);
      m_lfsr = sd;
      m_q.delete();
      foreach (m_used[i]) m_used[i] = 1'b0;
   endfunction

   function automatic void model_step(bit st, bit go, bit upd, bit md, int sd);
      int cand;
      bit all;
      if (st) begin
         model_clear((sd != 0) ? sd : 32'h0000_ACE1);
         return;
      end
      if (go) return;
      cand = m_lfsr % (1 << IW);
      if (upd && m_q.size() == DEPTH) void'(m_q.pop_front());
      if (cand < NT && (!md || !m_used[cand]) && m_q.size() < DEPTH) begin
         m_q.push_back(cand);
         if (md) begin
            m_used[cand] = 1'b1;
            all = 1'b1;
            foreach (m_used[i]) all &= m_used[i];
            if (all) foreach (m_used[i]) m_used[i] = 1'b0;
         end
      end
      m_lfsr = lfsr_next(m_lfsr);
   endfunction

   typedef struct {
      logic [IW-1:0]    idx;
      logic [PV*IW-1:0] prev;
      logic             v;
      logic [IW:0]      rem;
   } exp_t;

   function automatic exp_t model_out();
      exp_t e;
      e.idx  = (m_q.size() > 0) ? IW'(m_q[0]) : '0;
      e.prev = '0;
      for (int k = 1; k <= PV; k++)
         if (m_q.size() > k) e.prev[k*IW-1 -: IW] = IW'(m_q[k]);
      e.v   = (m_q.size() == DEPTH);
      e.rem = (IW+1)'(NT);
      foreach (m_used[i]) if (m_used[i]) e.rem = e.rem - 1'b1;
      return e;
   endfunction

   // ---------------- scoreboard ----------------
   exp_t exp_q[$];
   exp_t mon_e;
   int   consumed[$];

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("Index", Index, mon_e.idx);
         check("preview", preview, mon_e.prev);
         check("valid", valid, mon_e.v);
         check("bag_remaining", bag_remaining, mon_e.rem);
      end
   end

   // Apply inputs now, predict the result of the coming edge, wait past it.
   task automatic drive(bit st, bit go, bit upd, bit md, logic [15:0] sd);
      start = st; gameover = go; update = upd; mode = md; seed_in = sd;
      if (upd && valid && !go && !st) begin
         consumed.push_back(int'(Index));
         if (verbose)
            $display("pop %0d: piece=%0d preview=%h bag_remaining=%0d",
                     consumed.size(), Index, preview, bag_remaining);
      end
      model_step(st, go, upd, md, int'(sd));
      exp_q.push_back(model_out());
      @(posedge clk);
      #2;
   endtask

   task automatic tick(bit st, bit go, bit upd, bit md, logic [15:0] sd);
      @(negedge clk);
      drive(st, go, upd, md, sd);
   endtask

   task automatic wait_valid(int limit, bit md, string name);
      int n = 0;
      while (!valid && n < limit) begin
         tick(1'b0, 1'b0, 1'b0, md, 16'h0);
         n++;
      end
      check(name, valid, 1);
   endtask

   task automatic pop_n(int target, bit md, int budget, string name);
      int n = 0;
      while (consumed.size() < target && n < budget) begin
         tick(1'b0, 1'b0, valid, md, 16'h0);
         n++;
      end
      check(name, consumed.size(), target);
   endtask

   int first7[$];
   int runs[2][$];
   int hist[8];
   bit upd_pat[40];

   initial begin
      int bad, n;
      logic [15:0] rs;
      bit md;

      // ---- reset state and first fill ----
      model_clear(32'h0000_ACE1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_index", Index, 0);
      check("rst_preview", preview, 0);
      check("rst_valid", valid, 0);
      check("rst_bag_remaining", bag_remaining, 7);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
      wait_valid(64, 1'b1, "valid_after_start");
      pop_n(3, 1'b1, 200, "early_pops");

      // ---- asynchronous reset mid-cycle ----
      start = 1'b0; update = 1'b0; gameover = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("async_rst_index", Index, 0);
      check("async_rst_preview", preview, 0);
      check("async_rst_valid", valid, 0);
      check("async_rst_bag_remaining", bag_remaining, 7);
      model_clear(32'h0000_ACE1);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);

      // ---- bag property ----
      consumed.delete();
      tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
      wait_valid(64, 1'b1, "bag_fill");
      pop_n(21, 1'b1, 3000, "bag_pops");
      for (int g = 0; g < 3; g++) begin
         int seen = 0;
         for (int j = 0; j < 7; j++)
            if (g*7 + j < consumed.size()) seen |= (1 << consumed[g*7 + j]);
         check("bag_permutation", seen, 32'h7F);
      end
      first7.delete();
      for (int j = 0; j < 7 && j < consumed.size(); j++) first7.push_back(consumed[j]);

      // ---- uniform mode statistics and repeatability ----
      verbose = 1'b0;
      rs = 16'($urandom_range(1, 65535));
      consumed.delete();
      tick(1'b1, 1'b0, 1'b0, 1'b0, rs);
      wait_valid(64, 1'b0, "uniform_fill");
      pop_n(10000, 1'b0, 30000, "uniform_pops");
      foreach (hist[i]) hist[i] = 0;
      bad = 0;
      foreach (consumed[i]) begin
         if (consumed[i] >= NT || consumed[i] < 0) bad++;
         else hist[consumed[i]]++;
      end
      check("uniform_range", bad, 0);
      for (int t = 0; t < NT; t++) begin
         checks++;
         if (hist[t] < 1279 || hist[t] > 1579) begin
            errors++;
            $display("FAIL uniform_hist type %0d: count %0d, required 1279..1579", t, hist[t]);
         end
      end
      runs[0].delete();
      for (int j = 0; j < 50; j++) runs[0].push_back(consumed[j]);
      consumed.delete();
      tick(1'b1, 1'b0, 1'b0, 1'b0, rs);
      wait_valid(64, 1'b0, "repeat_fill");
      pop_n(50, 1'b0, 500, "repeat_pops");
      bad = 0;
      for (int j = 0; j < 50 && j < consumed.size(); j++)
         if (consumed[j] != runs[0][j]) bad++;
      check("repeat_seq_mismatches", bad, 0);
      verbose = 1'b1;

      // ---- freeze: run with a 20-cycle gameover vs. run without ----
      foreach (upd_pat[i]) upd_pat[i] = 1'($urandom_range(0, 1));
      for (int r = 0; r < 2; r++) begin
         consumed.delete();
         tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A);
         wait_valid(64, 1'b1, "freeze_fill");
         for (int i = 0; i < 40; i++) begin
            if (r == 0 && i == 15)
               for (int j = 0; j < 20; j++) tick(1'b0, 1'b1, 1'(j % 2), 1'b1, 16'h0);
            tick(1'b0, 1'b0, upd_pat[i], 1'b1, 16'h0);
         end
         runs[r] = consumed;
      end
      check("freeze_len", runs[0].size(), runs[1].size());
      bad = 0;
      for (int j = 0; j < runs[0].size() && j < runs[1].size(); j++)
         if (runs[0][j] != runs[1][j]) bad++;
      check("freeze_seq_mismatches", bad, 0);

      // ---- restart mid-fill ----
      consumed.delete();
      tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
      n = 0;
      while (m_q.size() < 2 && n < 20) begin
         tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
         n++;
      end
      check("midfill_count", m_q.size(), 2);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
      check("restart_valid", valid, 0);
      check("restart_index", Index, 0);
      check("restart_preview", preview, 0);
      check("restart_bag_remaining", bag_remaining, 7);
      wait_valid(64, 1'b1, "restart_fill");
      pop_n(7, 1'b1, 1000, "restart_pops");
      bad = 0;
      for (int j = 0; j < 7 && j < consumed.size() && j < first7.size(); j++)
         if (consumed[j] != first7[j]) bad++;
      check("restart_seq_mismatches", bad, 0);

      // ---- randomized mix of start / gameover / update / mode ----
      md = 1'b1;
      for (int i = 0; i < 600; i++) begin
         bit st, go, upd;
         logic [15:0] sd;
         st  = ($urandom_range(0, 59) == 0);
         go  = ($urandom_range(0, 9) == 0);
         upd = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) md = ~md;
         sd  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         tick(st, go, upd, md, sd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
